// File: rtl/deser_rr_sched_if.sv
// Requester / deserializer / tag-consumer signal bundle for deser_rr_sched.
// master = scheduler side, slave = surrounding environment.
interface deser_rr_sched_if #(
   parameter int NUM_REQ   = 4,
   parameter int INLOGBITS = 3
);
   localparam int INWIDTH = 1 << INLOGBITS;
   localparam int IDW     = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*INWIDTH-1:0] req_data;
   logic                       des_valid;
   logic                       des_ready;
   logic [INWIDTH-1:0]         des_data;
   logic                       tag_valid;
   logic                       tag_ready;
   logic [IDW-1:0]             tag_id;
   logic                       busy;

   modport master (
      input  req_valid, req_data, des_ready, tag_ready,
      output req_ready, des_valid, des_data, tag_valid, tag_id, busy
   );

   modport slave (
      output req_valid, req_data, des_ready, tag_ready,
      input  req_ready, des_valid, des_data, tag_valid, tag_id, busy
   );
endinterface

// File: rtl/deser_rr_sched.sv
// Round-robin scheduler granting one deserializer word at a time; source IDs queued in a tag FIFO.
// Optional DESER_RR_SCHED_PRIO0_EN: requester 0 wins every arbitration it takes part in.
module deser_rr_sched #(
   parameter int NUM_REQ    = 4,
   parameter int INLOGBITS  = 3,
   parameter int OUTLOGBITS = 6,
   parameter int TAG_DEPTH  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   deser_rr_sched_if.master bus
);
   localparam int INWIDTH = 1 << INLOGBITS;
   localparam int BEATS   = 1 << (OUTLOGBITS - INLOGBITS);
   localparam int MAXCNT  = BEATS - 1;
   localparam int IDW     = $clog2(NUM_REQ);
   localparam int CNTW    = OUTLOGBITS - INLOGBITS;
   localparam int PW      = $clog2(TAG_DEPTH);
   localparam int CW      = $clog2(TAG_DEPTH + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state;
   logic [IDW-1:0]  grant;
   logic [IDW-1:0]  last;
   logic [IDW-1:0]  pick;
   logic [CNTW-1:0] cnt;
   logic [IDW-1:0]  mem [TAG_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_n;
   logic [IDW-1:0]  tag_id_q;
   logic            locked;
   logic            fifo_full;
   logic            stall;
   logic            xfer;
   logic            push;
   logic            pop;

   // Search last+1, last+2, ...; iterating from the far end lets the nearest hit win.
   always_comb begin
      logic [IDW-1:0] cand;
      cand = '0;
      pick = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IDW'((int'(last) + k) % NUM_REQ);
`ifdef DESER_RR_SCHED_PRIO0_EN
         if (bus.req_valid[cand] && (cand != '0)) pick = cand;
`else
         if (bus.req_valid[cand]) pick = cand;
`endif
      end
`ifdef DESER_RR_SCHED_PRIO0_EN
      if (bus.req_valid[0]) pick = '0;
`endif
   end

   // Only the final beat waits on tag space; full is the registered occupancy, no pop bypass.
   always_comb begin
      locked        = (state == LOCKED);
      fifo_full     = (count == CW'(TAG_DEPTH));
      stall         = (cnt == CNTW'(MAXCNT)) && fifo_full;
      bus.des_valid = locked && bus.req_valid[grant] && !stall;
      bus.des_data  = locked ? bus.req_data[int'(grant)*INWIDTH +: INWIDTH] : '0;
      bus.req_ready = '0;
      if (locked && bus.des_ready && !stall) bus.req_ready[grant] = 1'b1;
      xfer          = bus.des_valid && bus.des_ready;
      push          = xfer && (cnt == CNTW'(MAXCNT));
      pop           = (count != '0) && bus.tag_ready;
      count_n       = count + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         last     <= IDW'(NUM_REQ - 1);
         cnt      <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         tag_id_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  grant <= pick;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (xfer) begin
                  cnt <= cnt + 1'b1;
                  if (push) begin
                     last  <= grant;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (push) begin
            mem[wr_ptr] <= grant;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count_n;

         // Registered head: track what the head will be after this cycle's push/pop.
         if (count_n == '0)
            tag_id_q <= '0;
         else if ((count == '0) || (pop && (count == CW'(1))))
            tag_id_q <= grant;
         else if (pop)
            tag_id_q <= mem[rd_ptr + PW'(1)];
      end
   end

   assign bus.busy      = (state == LOCKED);
   assign bus.tag_valid = (count != '0);
   assign bus.tag_id    = tag_id_q;
endmodule

// File: tb/tb_deser_rr_sched.sv
// Scoreboard bench for deser_rr_sched: expected beats/tags queued at stimulus time, checked on transfer/pop.
module tb_deser_rr_sched;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;
   int   xfers = 0;
   int   tag_pops = 0;
   int   cyc = 0;
   int   first_x = -1;
   int   last_x = -1;
   int   model_last = NR - 1;
   int   bn [NR];
   int   ebn [NR];
   logic [7:0] exp_beats [$];
   int   exp_tags [$];
   int   seen_tags [$];

   deser_rr_sched_if #(.NUM_REQ(NR), .INLOGBITS(3)) bus ();

   deser_rr_sched #(.NUM_REQ(NR), .INLOGBITS(3), .OUTLOGBITS(6), .TAG_DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] v);
      int j;
`ifdef DESER_RR_SCHED_PRIO0_EN
      if (v[0]) return 0;
`endif
      for (int k = 1; k <= NR; k++) begin
         j = (model_last + k) % NR;
`ifdef DESER_RR_SCHED_PRIO0_EN
         if (j != 0 && v[j]) return j;
`else
         if (v[j]) return j;
`endif
      end
      return 0;
   endfunction

   task automatic expect_word(input logic [NR-1:0] v);
      int g;
      g = rr_pick(v);
      model_last = g;
      for (int b = 0; b < 8; b++) begin
         exp_beats.push_back(8'(g * 64 + ebn[g] % 64));
         ebn[g]++;
      end
      exp_tags.push_back(g);
   endtask

   task automatic drive_data();
      for (int i = 0; i < NR; i++) bus.req_data[i*8 +: 8] = 8'(i * 64 + bn[i] % 64);
   endtask

   task automatic model_reset();
      exp_beats.delete();
      exp_tags.delete();
      for (int i = 0; i < NR; i++) begin
         bn[i]  = 0;
         ebn[i] = 0;
      end
      model_last = NR - 1;
      drive_data();
   endtask

   // One clock: observe at negedge, advance requester streams just after posedge.
   task automatic tick();
      logic [NR-1:0] acc;
      logic          xf;
      @(negedge clk);
      cyc++;
      acc = bus.req_valid & bus.req_ready;
      xf  = bus.des_valid && bus.des_ready;
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      chk("accept_vs_xfer", 32'(|acc), 32'(xf));
      if (xf) begin
         xfers++;
         if (first_x < 0) first_x = cyc;
         last_x = cyc;
         if (exp_beats.size() == 0) chk("beat_unexpected", 1, 0);
         else chk("des_data", bus.des_data, exp_beats.pop_front());
      end
      if (bus.tag_valid && bus.tag_ready) begin
         tag_pops++;
         seen_tags.push_back(int'(bus.tag_id));
         if (exp_tags.size() == 0) chk("tag_unexpected", 1, 0);
         else chk("tag_id", bus.tag_id, exp_tags.pop_front());
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) bn[i]++;
      drive_data();
   endtask

   task automatic run_until(input string tag, input int target);
      for (int n = 0; n < 300 && xfers < target; n++) tick();
      chk(tag, xfers, target);
   endtask

   task automatic drain(input string tag, input int n);
      bus.tag_ready = 1'b1;
      repeat (n) tick();
      chk({tag, "_beats_left"}, exp_beats.size(), 0);
      chk({tag, "_tags_left"}, exp_tags.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 0);
      chk({tag, "_des_valid"}, bus.des_valid, 0);
      chk({tag, "_des_data"}, bus.des_data, 0);
      chk({tag, "_tag_valid"}, bus.tag_valid, 0);
      chk({tag, "_tag_id"}, bus.tag_id, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      int base;
      int c0;
      int pops0;
      int order [4];
`ifdef DESER_RR_SCHED_PRIO0_EN
      order = '{0, 0, 0, 0};
`else
      order = '{0, 1, 2, 3};
`endif
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.des_ready = 1'b1;
      bus.tag_ready = 1'b1;
      model_reset();
      tick();
      tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // All requesters active: five words, one arbitration bubble between them.
      base = xfers;
      bus.req_valid = 4'b1111;
      c0 = cyc;
      first_x = -1;
      repeat (5) expect_word(4'b1111);
      run_until("t1_xfers", base + 40);
      bus.req_valid = '0;
      chk("t1_first_beat_cycle", first_x - c0, 2);
      chk("t1_span", last_x - first_x, 43);
      drain("t1", 3);

      // Granted requester goes quiet mid-word; grant must hold.
      base = xfers;
      bus.req_valid = 4'b0100;
      expect_word(4'b0100);
      run_until("t2_pre_gap", base + 3);
      bus.req_valid = 4'b0010;
      repeat (5) begin
         tick();
         chk("t2_gap_des_valid", bus.des_valid, 0);
         chk("t2_gap_req1_ready", bus.req_ready[1], 0);
         chk("t2_gap_busy", bus.busy, 1);
      end
      bus.req_valid = 4'b0110;
      expect_word(4'b0110);
      run_until("t2_xfers", base + 16);
      bus.req_valid = '0;
      drain("t2", 3);

      // Tag FIFO full: final beat of the third word waits for a pop.
      base = xfers;
      bus.tag_ready = 1'b0;
      bus.req_valid = 4'b0001;
      repeat (3) expect_word(4'b0001);
      run_until("t3_pre_stall", base + 23);
      repeat (3) begin
         tick();
         chk("t3_stall_des_valid", bus.des_valid, 0);
         chk("t3_stall_tag_valid", bus.tag_valid, 1);
      end
      chk("t3_stall_xfers", xfers, base + 23);
      bus.tag_ready = 1'b1;
      tick();
      bus.tag_ready = 1'b0;
      chk("t3_release_des_valid", bus.des_valid, 1);
      tick();
      chk("t3_final_xfer", xfers, base + 24);
      bus.req_valid = '0;
      drain("t3", 4);

      // Deserializer backpressure toggling every cycle.
      base  = xfers;
      pops0 = tag_pops;
      bus.req_valid = 4'b1000;
      expect_word(4'b1000);
      for (int n = 0; n < 60 && xfers < base + 8; n++) begin
         bus.des_ready = ~bus.des_ready;
         tick();
      end
      bus.req_valid = '0;
      bus.des_ready = 1'b1;
      drain("t4", 4);
      chk("t4_xfer_count", xfers, base + 8);
      chk("t4_tag_count", tag_pops - pops0, 1);

      // Reset in the middle of a word.
      base = xfers;
      bus.req_valid = 4'b0100;
      expect_word(4'b0100);
      run_until("t5_pre_reset", base + 5);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_idle_outputs("midword_reset");
      model_reset();
      bus.req_valid = 4'b1111;
      base = xfers;
      expect_word(4'b1111);
      run_until("t5_xfers", base + 8);
      bus.req_valid = '0;
      drain("t5", 3);

      // Grant order from a fresh reset with everyone requesting.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      seen_tags.delete();
      base = xfers;
      bus.req_valid = 4'b1111;
      repeat (4) expect_word(4'b1111);
      run_until("t6_xfers", base + 32);
      bus.req_valid = '0;
      drain("t6", 3);
      for (int k = 0; k < 4; k++)
         chk("t6_grant_order", (k < seen_tags.size()) ? seen_tags[k] : -1, order[k]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/deser_rr_sched.md
Name: deser_rr_sched

Overview:
- Round-robin scheduler that shares one downstream deserializer (narrow-to-wide, 2^(OUTLOGBITS-INLOGBITS) beats per word) among NUM_REQ narrow byte streams, such as multiple camera lanes.
- Locks the grant for exactly one full output word, so beats from different sources never interleave inside a word.
- Records the source ID of each completed word in a small tag FIFO, which the consumer pops alongside each wide word.
- Sits between the requesters and the deserializer's input port; shares clk/rst_n with that deserializer.

Parameters:
- NUM_REQ, 4, number of requesting streams (2..8).
- INLOGBITS, 3, log2 of beat width; INWIDTH = 1<<INLOGBITS.
- OUTLOGBITS, 6, log2 of the deserializer word width; must match the deserializer instance.
- TAG_DEPTH, 2, tag FIFO depth (power of 2, at least 2).
- Derived localparams:
  - BEATS = 1<<(OUTLOGBITS-INLOGBITS)
  - MAXCNT = BEATS-1
  - IDW = clog2(NUM_REQ)

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept; at most one bit high.
- req_data  in  NUM_REQ*INWIDTH  packed beats; requester i occupies [i*INWIDTH +: INWIDTH].
- des_valid  out  1  beat valid to the deserializer's in_valid.
- des_ready  in  1  the deserializer's in_ready.
- des_data  out  INWIDTH  beat to the deserializer's in_data.
- tag_valid  out  1  tag FIFO non-empty.
- tag_ready  in  1  consumer pops one tag; asserted in the same cycle it accepts the deserializer's output word.
- tag_id  out  IDW  source index of the oldest completed word.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset (rst_n=0 at posedge) sets the following, and overrides all other activity, including a reset mid-word:
  - state=IDLE, grant=0, last=NUM_REQ-1, cnt=0, FIFO empty.
  - Outputs: req_ready=0, des_valid=0, des_data=0, tag_valid=0, tag_id=0, busy=0.
- The deserializer is reset by the same rst_n, so beat alignment is preserved.
- State machine:
  - IDLE: if any req_valid is high, grant = first set bit searching last+1, last+2, ... modulo NUM_REQ; go to LOCKED. One-cycle arbitration bubble. No beat transfers in IDLE.
  - LOCKED: pass-through of requester g=grant, all combinational:
    - des_data = req_data[g]
    - des_valid = req_valid[g] && !stall
    - req_ready[g] = des_ready && !stall
    - all other req_ready bits = 0
  - stall = (cnt==MAXCNT) && fifo_full. Only the final beat of a word is held. fifo_full is the registered occupancy before any same-cycle pop; there is no bypass.
- Handshake and counting:
  - A beat transfers when des_valid && des_ready; cnt increments and wraps at BEATS.
  - When the transferring beat has cnt==MAXCNT: push g into the tag FIFO, set last=g, go to IDLE.
  - The grant never changes mid-word, even if req_valid[g] drops; the scheduler waits indefinitely.
- Tag FIFO:
  - Pop occurs on tag_valid && tag_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - A pop while empty is ignored.
  - tag_id is registered FIFO head data; 0 when empty.
- busy is high exactly while state==LOCKED.
- Latency:
  - A request arriving with the scheduler in IDLE sees req_ready as early as the next cycle.
  - Its tag becomes visible the cycle after its final beat transfers.
  - Back-to-back words cost BEATS+1 cycles minimum.

Optional Feature:
- DESER_RR_SCHED_PRIO0_EN
- Defined: in IDLE, requester 0 wins whenever req_valid[0]=1, regardless of last; otherwise normal round-robin among 1..NUM_REQ-1. Requester 0 can starve the others, by design. Used for the control/metadata lane.
- Undefined: pure round-robin as above; there is no priority logic in the netlist.

Test Plan:
- Reset then all req_valid=4'b1111, des_ready=1, tag_ready=1 (BEATS=8) -> grants in order 0,1,2,3,0; each word is 8 beats followed by 1 idle cycle; tag_id sequence 0,1,2,3.
- Requester 2 holds valid, drops req_valid[2] after beat 3 for 5 cycles, requester 1 requesting -> grant stays 2, des_valid=0 during the gap, req_ready[1]=0; word completes with tag_id=2.
- tag_ready=0, two words complete (FIFO full, TAG_DEPTH=2), third word -> beats 0..6 transfer, beat 7 held (des_valid=0); tag_ready=1 for one cycle -> beat 7 transfers the next cycle.
- des_ready toggling 1,0,1,0 during a word -> exactly 8 transfers counted; only one tag is pushed.
- rst_n=0 for 1 cycle after beat 4 of a word -> next cycle all outputs 0, state IDLE; the next word starts at cnt=0 with a fresh grant from requester 0.
- With DESER_RR_SCHED_PRIO0_EN defined, req_valid=4'b1111 held -> grant is 0 for every word; without it -> 0,1,2,3.
